// File: rtl/mod_exp_pkg.sv
// Shared types and width helpers for the modular exponentiation engine.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRERED = 3'd1,
    SQUARE = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int prod_width(input int n_w);
    return 2 * n_w;
  endfunction

endpackage

// File: rtl/mod_exp_reduce.sv
// Sequential restoring remainder: captures a P_W-bit value, then folds in one bit per cycle.
module mod_reduce
  import mod_exp_pkg::*;
#(
  parameter int N_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [prod_width(N_W)-1:0] num,
  input  logic [N_W-1:0]             N,
  output logic [N_W-1:0]             rem,
  output logic                       done
);

  localparam int P_W   = prod_width(N_W);
  localparam int CNT_W = $clog2(P_W + 1);

  logic [P_W-1:0]   num_q, num_d;
  logic [P_W-1:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [P_W:0]     r_sh;
  logic [P_W:0]     n_ext;

  assign n_ext = {{(P_W + 1 - N_W){1'b0}}, N};

  always_comb begin
    num_d  = num_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    r_sh   = {r_q, num_q[P_W-1]};
    if (go) begin
      num_d  = num;
      r_d    = '0;
      cnt_d  = CNT_W'(P_W);
      busy_d = 1'b1;
    end else if (busy_q && cnt_q != '0) begin
      // r stays below N, so the shifted value fits in P_W+1 bits
      r_d   = (r_sh >= n_ext) ? P_W'(r_sh - n_ext) : r_sh[P_W-1:0];
      num_d = num_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q  <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      num_q  <= num_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign rem  = r_q[N_W-1:0];

endmodule

// File: rtl/mod_exp_engine.sv
// Constant-time left-to-right square-and-multiply engine computing base^expo mod N.
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int BASE_W = 6,
  parameter int EXP_W  = 6,
  parameter int N_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BASE_W-1:0] base,
  input  logic [EXP_W-1:0]  expo,
  input  logic [N_W-1:0]    N,
  output logic              ready,
  output logic [N_W-1:0]    result,
  output logic              valid,
  output logic              error
);

  localparam int P_W   = prod_width(N_W);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_t            state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [EXP_W-1:0]  expo_q, expo_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [N_W-1:0]    acc_q, acc_d;
  logic [N_W-1:0]    b_red_q, b_red_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              error_q, error_d;
  logic              kick_q, kick_d;

  logic              red_go;
  logic              red_from_base;
  logic              red_done;
  logic [N_W-1:0]    red_rem;
  logic [N_W-1:0]    mul_b;
  logic [P_W-1:0]    prod;
  logic [P_W-1:0]    red_num;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    expo_d        = expo_q;
    n_d           = n_q;
    acc_d         = acc_q;
    b_red_d       = b_red_q;
    idx_d         = idx_q;
    error_d       = error_q;
    kick_d        = kick_q;
    red_go        = 1'b0;
    red_from_base = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          base_d  = base;
          expo_d  = expo;
          n_d     = N;
          error_d = (N == '0);
          idx_d   = IDX_W'(EXP_W - 1);
          b_red_d = '0;
          kick_d  = (N != '0);
          acc_d   = (N == '0 || N == N_W'(1)) ? '0 : N_W'(1);
          state_d = (N == '0) ? DONE : PRERED;
        end
      end
      PRERED: begin
        if (kick_q) begin
          red_go        = 1'b1;
          red_from_base = 1'b1;
          kick_d        = 1'b0;
        end else if (red_done) begin
          b_red_d = red_rem;
          state_d = SQUARE;
          red_go  = 1'b1;
        end
      end
      SQUARE: begin
        if (red_done) begin
          acc_d   = red_rem;
          state_d = MULT;
          red_go  = 1'b1;
        end
      end
      MULT: begin
        // The multiply is always reduced; only the writeback depends on the key bit
        if (red_done) begin
          if (expo_q[idx_q]) acc_d = red_rem;
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQUARE;
            red_go  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands come from next-state values so the next reduction launches without a gap
  always_comb begin
    mul_b   = (state_d == MULT) ? b_red_q : acc_d;
    prod    = {{N_W{1'b0}}, acc_d} * {{N_W{1'b0}}, mul_b};
    red_num = red_from_base ? P_W'(base_q) : prod;
  end

  mod_reduce #(.N_W(N_W)) u_reduce (
    .clk  (clk),
    .rst  (rst),
    .go   (red_go),
    .num  (red_num),
    .N    (n_q),
    .rem  (red_rem),
    .done (red_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      expo_q  <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      b_red_q <= '0;
      idx_q   <= '0;
      error_q <= 1'b0;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      expo_q  <= expo_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      b_red_q <= b_red_d;
      idx_q   <= idx_d;
      error_q <= error_d;
      kick_q  <= kick_d;
    end
  end

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign valid  = (state_q == DONE);
  assign result = valid ? acc_q : '0;
  assign error  = error_q;

endmodule
